// File: rtl/mic_olimit_slice_pkg.sv
// Shared beat definitions for the MIC outstanding-limiter slice.
package mic_olimit_slice_pkg;

    localparam int MIC_DATA_W = 64;
    localparam int MIC_BEAT_W = MIC_DATA_W + 1;

    // One stream beat as carried through the skid buffers: {TLAST, TDATA}.
    typedef logic [MIC_BEAT_W-1:0] mic_beat_t;

    function automatic mic_beat_t pack_beat(input logic last, input logic [MIC_DATA_W-1:0] data);
        return {last, data};
    endfunction

endpackage

// File: rtl/mic_olimit_slice_skid2.sv
// Two-entry valid/ready buffer with a registered ready; the head entry drives
// the output directly so nothing combinational reaches the outputs.
module mic_skid2 #(
    parameter int W = 65
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [1:0]   fill;
    logic [1:0]   fill_nxt;
    logic [W-1:0] data_p0;
    logic [W-1:0] data_p1;
    logic         vld_p0;
    logic         rdy_r;
    logic         push;
    logic         pop;

    assign push      = in_valid & rdy_r;
    assign pop       = vld_p0 & out_ready;
    assign in_ready  = rdy_r;
    assign out_valid = vld_p0;
    assign out_data  = data_p0;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        fill_nxt = fill;
        case ({push, pop})
            2'b10:   fill_nxt = fill + 2'd1;
            2'b01:   fill_nxt = fill - 2'd1;
            default: fill_nxt = fill;
        endcase
    end

    // Head (p0) / skid (p1) storage; ready and valid are registered from the next fill.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill    <= 2'd0;
            vld_p0  <= 1'b0;
            rdy_r   <= 1'b0;
            data_p0 <= '0;
            data_p1 <= '0;
        end else begin
            fill   <= fill_nxt;
            vld_p0 <= (fill_nxt != 2'd0);
            rdy_r  <= (fill_nxt != 2'd2);
            if (pop) begin
                if (fill == 2'd2) begin
                    data_p0 <= data_p1;
                end else if (push) begin
                    data_p0 <= in_data;
                end
            end else if (push) begin
                if (fill == 2'd0) begin
                    data_p0 <= in_data;
                end else begin
                    data_p1 <= in_data;
                end
            end
        end
    end

endmodule

// File: rtl/mic_olimit_slice.sv
// Registered request/response slice that caps the number of request packets
// awaiting a response. Gating applies only at packet start.
module mic_olimit_slice
    import mic_olimit_slice_pkg::*;
#(
    parameter int   MAX_OUTSTANDING = 4,
    localparam int  CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  UI_TVALID,
    output logic                  UI_TREADY,
    input  logic [MIC_DATA_W-1:0] UI_TDATA,
    input  logic                  UI_TLAST,
    output logic                  UO_TVALID,
    input  logic                  UO_TREADY,
    output logic [MIC_DATA_W-1:0] UO_TDATA,
    output logic                  UO_TLAST,
    output logic                  DO_TVALID,
    input  logic                  DO_TREADY,
    output logic [MIC_DATA_W-1:0] DO_TDATA,
    output logic                  DO_TLAST,
    input  logic                  DI_TVALID,
    output logic                  DI_TREADY,
    input  logic [MIC_DATA_W-1:0] DI_TDATA,
    input  logic                  DI_TLAST,
    output logic [CNT_W-1:0]      outstanding,
    output logic                  underflow_err
);

    logic             slice_rdy;
    logic             below_max;
    logic             in_pkt;
    logic             admit;
    logic             ui_hs;
    logic             req_start;
    logic             resp_last;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    mic_beat_t        do_beat;
    mic_beat_t        uo_beat;

    // Beats inside a packet always pass; a new packet needs headroom.
    assign admit     = in_pkt | below_max;
    assign UI_TREADY = slice_rdy & admit;
    assign ui_hs     = UI_TVALID & UI_TREADY;
    assign req_start = ui_hs & ~in_pkt;
    assign resp_last = DI_TVALID & DI_TREADY & DI_TLAST;

    assign outstanding = cnt;
    assign DO_TLAST    = do_beat[MIC_BEAT_W-1];
    assign DO_TDATA    = do_beat[MIC_DATA_W-1:0];
    assign UO_TLAST    = uo_beat[MIC_BEAT_W-1];
    assign UO_TDATA    = uo_beat[MIC_DATA_W-1:0];

    mic_skid2 #(.W(MIC_BEAT_W)) u_req_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (UI_TVALID & admit),
        .in_ready  (slice_rdy),
        .in_data   (pack_beat(UI_TLAST, UI_TDATA)),
        .out_valid (DO_TVALID),
        .out_ready (DO_TREADY),
        .out_data  (do_beat)
    );

    mic_skid2 #(.W(MIC_BEAT_W)) u_rsp_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (DI_TVALID),
        .in_ready  (DI_TREADY),
        .in_data   (pack_beat(DI_TLAST, DI_TDATA)),
        .out_valid (UO_TVALID),
        .out_ready (UO_TREADY),
        .out_data  (uo_beat)
    );

    // In-flight count: start and completion in the same cycle cancel; never wraps below 0.
    always_comb begin
        cnt_nxt = cnt;
        if (req_start && !resp_last) begin
            cnt_nxt = cnt + CNT_W'(1);
        end else if (resp_last && !req_start && (cnt != '0)) begin
            cnt_nxt = cnt - CNT_W'(1);
        end
    end

    // Count, packet-tracking flag, registered headroom and sticky underflow.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt           <= '0;
            below_max     <= 1'b1;
            in_pkt        <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            below_max <= (cnt_nxt < CNT_W'(MAX_OUTSTANDING));
            if (ui_hs) begin
                in_pkt <= ~UI_TLAST;
            end
            if (resp_last && !req_start && (cnt == '0)) begin
                underflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mic_olimit_slice.sv
// Bench for mic_olimit_slice: directed traffic plus a queue-based reference model.
module tb_mic_olimit_slice;

    localparam int MAX = 4;
    localparam int TMO = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic        UI_TVALID, UI_TREADY, UI_TLAST;
    logic [63:0] UI_TDATA;
    logic        UO_TVALID, UO_TREADY, UO_TLAST;
    logic [63:0] UO_TDATA;
    logic        DO_TVALID, DO_TREADY, DO_TLAST;
    logic [63:0] DO_TDATA;
    logic        DI_TVALID, DI_TREADY, DI_TLAST;
    logic [63:0] DI_TDATA;
    logic [2:0]  outstanding;
    logic        underflow_err;

    always #5 clk = ~clk;

    mic_olimit_slice #(.MAX_OUTSTANDING(MAX)) dut (
        .clk(clk), .reset(reset),
        .UI_TVALID(UI_TVALID), .UI_TREADY(UI_TREADY), .UI_TDATA(UI_TDATA), .UI_TLAST(UI_TLAST),
        .UO_TVALID(UO_TVALID), .UO_TREADY(UO_TREADY), .UO_TDATA(UO_TDATA), .UO_TLAST(UO_TLAST),
        .DO_TVALID(DO_TVALID), .DO_TREADY(DO_TREADY), .DO_TDATA(DO_TDATA), .DO_TLAST(DO_TLAST),
        .DI_TVALID(DI_TVALID), .DI_TREADY(DI_TREADY), .DI_TDATA(DI_TDATA), .DI_TLAST(DI_TLAST),
        .outstanding(outstanding), .underflow_err(underflow_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [64:0] do_q[$];
    logic [64:0] uo_q[$];
    int          m_cnt = 0;
    logic        m_in_pkt = 1'b0;
    logic        m_uf = 1'b0;
    logic        armed = 1'b0;
    int          do_popped = 0;

    always @(negedge clk) begin
        logic st, rl, e;
        st = 1'b0;
        rl = 1'b0;
        if (!reset) begin
            do_q.delete();
            uo_q.delete();
            m_cnt    = 0;
            m_in_pkt = 1'b0;
            m_uf     = 1'b0;
            armed    = 1'b0;
        end else begin
            e = armed && (do_q.size() < 2) && (m_in_pkt || (m_cnt < MAX));
            check("m_ui_tready", {64'd0, UI_TREADY}, {64'd0, e});
            e = armed && (uo_q.size() < 2);
            check("m_di_tready", {64'd0, DI_TREADY}, {64'd0, e});
            e = (do_q.size() != 0);
            check("m_do_tvalid", {64'd0, DO_TVALID}, {64'd0, e});
            e = (uo_q.size() != 0);
            check("m_uo_tvalid", {64'd0, UO_TVALID}, {64'd0, e});
            if (DO_TVALID && do_q.size() != 0) check("m_do_beat", {DO_TLAST, DO_TDATA}, do_q[0]);
            if (UO_TVALID && uo_q.size() != 0) check("m_uo_beat", {UO_TLAST, UO_TDATA}, uo_q[0]);
            check("m_outstanding", {62'd0, outstanding}, 65'(m_cnt));
            check("m_underflow", {64'd0, underflow_err}, {64'd0, m_uf});

            // Transfers that the next rising edge will complete.
            if (DO_TVALID && DO_TREADY && do_q.size() != 0) begin
                void'(do_q.pop_front());
                do_popped++;
            end
            if (UO_TVALID && UO_TREADY && uo_q.size() != 0) void'(uo_q.pop_front());
            if (UI_TVALID && UI_TREADY) begin
                do_q.push_back({UI_TLAST, UI_TDATA});
                st = !m_in_pkt;
                m_in_pkt = !UI_TLAST;
            end
            if (DI_TVALID && DI_TREADY) begin
                uo_q.push_back({DI_TLAST, DI_TDATA});
                rl = DI_TLAST;
            end
            if (st && !rl) m_cnt++;
            else if (rl && !st) begin
                if (m_cnt == 0) m_uf = 1'b1;
                else m_cnt--;
            end
            armed = 1'b1;
        end
    end

    // ---------------- drivers (called at posedge+1) ----------------
    task automatic ui_send(input logic [63:0] d, input logic l, output int waited);
        waited = 0;
        UI_TVALID = 1'b1; UI_TDATA = d; UI_TLAST = l;
        forever begin
            @(negedge clk);
            if (UI_TREADY) begin
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            waited++;
            if (waited >= TMO) begin
                n_checks++; n_fail++;
                $display("FAIL ui_timeout: got no handshake in %0d cycles, want handshake", waited);
                break;
            end
        end
        UI_TVALID = 1'b0;
    endtask

    task automatic di_send(input logic [63:0] d, input logic l, output int waited);
        waited = 0;
        DI_TVALID = 1'b1; DI_TDATA = d; DI_TLAST = l;
        forever begin
            @(negedge clk);
            if (DI_TREADY) begin
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            waited++;
            if (waited >= TMO) begin
                n_checks++; n_fail++;
                $display("FAIL di_timeout: got no handshake in %0d cycles, want handshake", waited);
                break;
            end
        end
        DI_TVALID = 1'b0;
    endtask

    int   w, w5, wa, wb;
    int   sent = 0;
    int   base_pop;
    logic stop_rand = 1'b0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, want end");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        UI_TVALID = 0; UI_TDATA = '0; UI_TLAST = 0;
        DI_TVALID = 0; DI_TDATA = '0; DI_TLAST = 0;
        DO_TREADY = 1; UO_TREADY = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ui_tready", {64'd0, UI_TREADY}, 65'd0);
        check("rst_di_tready", {64'd0, DI_TREADY}, 65'd0);
        check("rst_do_tvalid", {64'd0, DO_TVALID}, 65'd0);
        check("rst_uo_tvalid", {64'd0, UO_TVALID}, 65'd0);
        check("rst_do_beat", {DO_TLAST, DO_TDATA}, 65'd0);
        check("rst_outstanding", {62'd0, outstanding}, 65'd0);
        check("rst_underflow", {64'd0, underflow_err}, 65'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rel_ui_tready", {64'd0, UI_TREADY}, 65'd1);
        check("rel_di_tready", {64'd0, DI_TREADY}, 65'd1);

        // Single 3-beat request, 1-beat response.
        ui_send(64'h11, 1'b0, w);
        check("t1_cnt_first", {62'd0, outstanding}, 65'd1);
        check("t1_do_first", {DO_TVALID, DO_TLAST, DO_TDATA}, {2'b10, 64'h11});
        ui_send(64'h22, 1'b0, w);
        ui_send(64'h33, 1'b1, w);
        check("t1_do_last", {DO_TLAST, DO_TDATA}, {1'b1, 64'h33});
        repeat (2) begin @(posedge clk); #1; end
        di_send(64'hAA, 1'b1, w);
        check("t1_cnt_resp", {62'd0, outstanding}, 65'd0);
        check("t1_uo_beat", {UO_TVALID, UO_TLAST, UO_TDATA}, {2'b11, 64'hAA});

        // Limit: four single-beat starts, fifth held until a response.
        for (int i = 0; i < 4; i++) ui_send(64'h100 + 64'(i), 1'b1, w);
        check("t2_cnt_max", {62'd0, outstanding}, 65'd4);
        fork
            ui_send(64'h104, 1'b1, w5);
        join_none
        repeat (5) begin
            @(negedge clk);
            check("t2_stall", {64'd0, UI_TREADY}, 65'd0);
        end
        @(posedge clk); #1;
        di_send(64'hB0, 1'b1, w);
        check("t2_cnt_after_resp", {62'd0, outstanding}, 65'd3);
        check("t2_rdy_back", {64'd0, UI_TREADY}, 65'd1);
        wait fork;
        check("t2_cnt_refill", {62'd0, outstanding}, 65'd4);
        di_send(64'hB1, 1'b1, w);
        check("t3_cnt_start", {62'd0, outstanding}, 65'd3);

        // Mid-packet beats are never gated by the count.
        for (int i = 0; i < 4; i++) begin
            ui_send(64'h200 + 64'(i), (i == 3), w);
            check("t3_nostall", 65'(w), 65'd0);
            if (i == 0) check("t3_cnt_hit", {62'd0, outstanding}, 65'd4);
        end
        for (int i = 0; i < 4; i++) di_send(64'hC0 + 64'(i), 1'b1, w);
        check("t3_cnt_drained", {62'd0, outstanding}, 65'd0);

        // Packet start and response TLAST in the same cycle.
        ui_send(64'h300, 1'b1, w);
        ui_send(64'h301, 1'b1, w);
        fork
            ui_send(64'h302, 1'b1, wa);
            di_send(64'hD0, 1'b1, wb);
        join
        check("t5_same_cycle", {65'(wa), 65'(wb)} == 130'd0 ? 65'd1 : 65'd0, 65'd1);
        check("t5_cnt_hold", {62'd0, outstanding}, 65'd2);
        for (int i = 0; i < 2; i++) di_send(64'hD1 + 64'(i), 1'b1, w);
        check("t5_cnt_drained", {62'd0, outstanding}, 65'd0);

        // Back-pressure: two beats absorbed, then a 1000-beat packet under random ready.
        base_pop = do_popped;
        DO_TREADY = 1'b0;
        fork
            begin
                int ws;
                for (int i = 0; i < 1000; i++) begin
                    ui_send(64'h5000 + 64'(i), (i == 999), ws);
                    sent++;
                end
            end
        join_none
        repeat (4) @(negedge clk);
        check("t4_absorbed", 65'(sent), 65'd2);
        check("t4_ui_low", {64'd0, UI_TREADY}, 65'd0);
        check("t4_do_head", {DO_TVALID, DO_TDATA}, {1'b1, 64'h5000});
        fork
            while (!stop_rand) begin
                @(posedge clk); #1;
                DO_TREADY = 1'($urandom_range(0, 1));
            end
        join_none
        for (int c = 0; c < 20000 && sent < 1000; c++) @(posedge clk);
        check("t4_all_sent", 65'(sent), 65'd1000);
        stop_rand = 1'b1;
        @(posedge clk); #2;
        DO_TREADY = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        check("t4_all_out", 65'(do_popped - base_pop), 65'd1000);
        check("t4_cnt", {62'd0, outstanding}, 65'd1);
        di_send(64'hE0, 1'b1, w);
        check("t4_cnt_drained", {62'd0, outstanding}, 65'd0);

        // Underflow.
        di_send(64'hF0, 1'b1, w);
        check("t6_underflow", {64'd0, underflow_err}, 65'd1);
        check("t6_cnt_zero", {62'd0, outstanding}, 65'd0);

        // Async reset mid-packet.
        DO_TREADY = 1'b0;
        ui_send(64'h600, 1'b0, w);
        ui_send(64'h601, 1'b0, w);
        #2;
        reset = 1'b0;
        #1;
        check("ar_ui_tready", {64'd0, UI_TREADY}, 65'd0);
        check("ar_di_tready", {64'd0, DI_TREADY}, 65'd0);
        check("ar_do", {DO_TVALID, DO_TLAST, DO_TDATA}, 66'd0);
        check("ar_uo", {UO_TVALID, UO_TLAST, UO_TDATA}, 66'd0);
        check("ar_outstanding", {62'd0, outstanding}, 65'd0);
        check("ar_underflow", {64'd0, underflow_err}, 65'd0);
        DO_TREADY = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("ar_rel_ui", {64'd0, UI_TREADY}, 65'd1);
        check("ar_rel_di", {64'd0, DI_TREADY}, 65'd1);
        ui_send(64'h700, 1'b1, w);
        check("ar_new_start", {62'd0, outstanding}, 65'd1);
        check("ar_new_do", {DO_TVALID, DO_TLAST, DO_TDATA}, {2'b11, 64'h700});
        di_send(64'h710, 1'b1, w);
        check("ar_cnt_end", {62'd0, outstanding}, 65'd0);
        repeat (3) begin @(posedge clk); #1; end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
